// File: rtl/branch_repair_unit_pkg.sv
// rtl/branch_repair_unit_pkg.sv - shared types and helpers for the branch repair unit
//
// Purpose : FSM state encoding, default widths and the fall-through PC helper
//           used by branch_repair_unit.
// Contents: BR_CKPT_W_DEF / BR_REPAIR_W_DEF default widths,
//           br_state_e one-hot state type,
//           br_fallthrough_pc() branch PC to not-taken target (skips delay slot).
package branch_repair_unit_pkg;

    localparam int BR_CKPT_W_DEF   = 32;
    localparam int BR_REPAIR_W_DEF = 4;

    // One-hot so each state decode is a single flop bit.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_WAIT_DS  = 4'b0010,
        ST_FLUSH    = 4'b0100,
        ST_REDIRECT = 4'b1000
    } br_state_e;

    // Not-taken resume point: branch + delay slot, wrapping at 32 bits.
    function automatic logic [31:0] br_fallthrough_pc(input logic [31:0] vaddr);
        return vaddr + 32'd8;
    endfunction

endpackage

// File: rtl/branch_repair_unit.sv
// rtl/branch_repair_unit.sv - mispredict repair: flush, checkpoint restore, IF redirect
//
// Purpose : Accepts one resolved mispredict from SBA, waits for its delay slot
//           to leave ID, flushes younger stages for one cycle while restoring
//           the predictor checkpoint, then holds a redirect to IF until IF
//           accepts it. A CP0 exception aborts the sequence in any state.
// Ports   : clk, rst_n (async active-low)
//           SBA_*_i       resolved branch bundle from SBA
//           ID_dsIssued_w_i, CP0_excOccur_w_i, IF_redirectReady_w_i
//           BR_busy_w_o, BR_flush_w_o, BR_restoreValid_o,
//           BR_restoreCheckPoint_o, BR_restoreAction_o,
//           BR_redirectValid_o, BR_redirectDest_o, BR_mispredCnt_o
// All outputs are registered; nothing from SBA_* reaches BR_redirect* in the same cycle.
module branch_repair_unit
    import branch_repair_unit_pkg::*;
#(
    parameter int CKPT_W    = BR_CKPT_W_DEF,
    parameter int REPAIR_W  = BR_REPAIR_W_DEF,
    parameter bit DS_BYPASS = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SBA_valid_w_i,
    input  logic                SBA_branchRisk_i,
    input  logic                SBA_corrTake_i,
    input  logic [31:0]         SBA_corrDest_i,
    input  logic [31:0]         SBA_VAddr_i,
    input  logic [REPAIR_W-1:0] SBA_repairAction_i,
    input  logic [CKPT_W-1:0]   SBA_checkPoint_i,
    input  logic                ID_dsIssued_w_i,
    input  logic                CP0_excOccur_w_i,
    input  logic                IF_redirectReady_w_i,
    output logic                BR_busy_w_o,
    output logic                BR_flush_w_o,
    output logic                BR_restoreValid_o,
    output logic [CKPT_W-1:0]   BR_restoreCheckPoint_o,
    output logic [REPAIR_W-2:0] BR_restoreAction_o,
    output logic                BR_redirectValid_o,
    output logic [31:0]         BR_redirectDest_o,
    output logic [31:0]         BR_mispredCnt_o
);

    br_state_e             state_q, state_d;
    logic                  accept;
    logic                  complete;

    logic                  busy_q;
    logic                  flush_q;
    logic                  restore_q;
    logic                  redir_valid_q;
    logic [CKPT_W-1:0]     ckpt_q;
    logic [REPAIR_W-2:0]   action_q;
    logic [31:0]           dest_q;
    logic [31:0]           cnt_q;

    // Next state; CP0 overrides every other transition.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        if (CP0_excOccur_w_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (SBA_valid_w_i && SBA_branchRisk_i && SBA_repairAction_i[REPAIR_W-1]) begin
                        accept = 1'b1;
                        if (DS_BYPASS) state_d = ST_FLUSH;
                        else           state_d = ST_WAIT_DS;
                    end
                end
                ST_WAIT_DS: begin
                    if (ID_dsIssued_w_i) state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    state_d = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (IF_redirectReady_w_i) begin
                        state_d  = ST_IDLE;
                        complete = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State plus registered outputs decoded from the next state, so each
    // output lines up exactly with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            flush_q       <= 1'b0;
            restore_q     <= 1'b0;
            redir_valid_q <= 1'b0;
            ckpt_q        <= '0;
            action_q      <= '0;
            dest_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= (state_d != ST_IDLE);
            flush_q       <= (state_d == ST_FLUSH);
            restore_q     <= (state_d == ST_FLUSH);
            redir_valid_q <= (state_d == ST_REDIRECT);
            if (accept) begin
                ckpt_q   <= SBA_checkPoint_i;
                action_q <= SBA_repairAction_i[REPAIR_W-2:0];
                dest_q   <= SBA_corrTake_i ? SBA_corrDest_i : br_fallthrough_pc(SBA_VAddr_i);
            end
            if (complete) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign BR_busy_w_o            = busy_q;
    assign BR_flush_w_o           = flush_q;
    assign BR_restoreValid_o      = restore_q;
    assign BR_restoreCheckPoint_o = ckpt_q;
    assign BR_restoreAction_o     = action_q;
    assign BR_redirectValid_o     = redir_valid_q;
    assign BR_redirectDest_o      = dest_q;
    assign BR_mispredCnt_o        = cnt_q;

endmodule

// File: tb/tb_branch_repair_unit.sv
// tb/tb_branch_repair_unit.sv - directed self-checking bench for branch_repair_unit
module tb_branch_repair_unit;

    logic        clk;
    logic        rst_n;
    logic        SBA_valid_w_i;
    logic        SBA_branchRisk_i;
    logic        SBA_corrTake_i;
    logic [31:0] SBA_corrDest_i;
    logic [31:0] SBA_VAddr_i;
    logic [3:0]  SBA_repairAction_i;
    logic [31:0] SBA_checkPoint_i;
    logic        ID_dsIssued_w_i;
    logic        CP0_excOccur_w_i;
    logic        IF_redirectReady_w_i;
    logic        BR_busy_w_o;
    logic        BR_flush_w_o;
    logic        BR_restoreValid_o;
    logic [31:0] BR_restoreCheckPoint_o;
    logic [2:0]  BR_restoreAction_o;
    logic        BR_redirectValid_o;
    logic [31:0] BR_redirectDest_o;
    logic [31:0] BR_mispredCnt_o;

    int checks   = 0;
    int failures = 0;

    branch_repair_unit #(
        .CKPT_W    (32),
        .REPAIR_W  (4),
        .DS_BYPASS (1'b0)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .SBA_valid_w_i          (SBA_valid_w_i),
        .SBA_branchRisk_i       (SBA_branchRisk_i),
        .SBA_corrTake_i         (SBA_corrTake_i),
        .SBA_corrDest_i         (SBA_corrDest_i),
        .SBA_VAddr_i            (SBA_VAddr_i),
        .SBA_repairAction_i     (SBA_repairAction_i),
        .SBA_checkPoint_i       (SBA_checkPoint_i),
        .ID_dsIssued_w_i        (ID_dsIssued_w_i),
        .CP0_excOccur_w_i       (CP0_excOccur_w_i),
        .IF_redirectReady_w_i   (IF_redirectReady_w_i),
        .BR_busy_w_o            (BR_busy_w_o),
        .BR_flush_w_o           (BR_flush_w_o),
        .BR_restoreValid_o      (BR_restoreValid_o),
        .BR_restoreCheckPoint_o (BR_restoreCheckPoint_o),
        .BR_restoreAction_o     (BR_restoreAction_o),
        .BR_redirectValid_o     (BR_redirectValid_o),
        .BR_redirectDest_o      (BR_redirectDest_o),
        .BR_mispredCnt_o        (BR_mispredCnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_branch(input logic take, input logic [31:0] cdest,
                                input logic [31:0] va, input logic [3:0] act,
                                input logic [31:0] ckpt);
        SBA_valid_w_i      = 1'b1;
        SBA_branchRisk_i   = 1'b1;
        SBA_corrTake_i     = take;
        SBA_corrDest_i     = cdest;
        SBA_VAddr_i        = va;
        SBA_repairAction_i = act;
        SBA_checkPoint_i   = ckpt;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"},  BR_busy_w_o,            0);
        check_val({tag, "_flush"}, BR_flush_w_o,           0);
        check_val({tag, "_rst"},   BR_restoreValid_o,      0);
        check_val({tag, "_ckpt"},  BR_restoreCheckPoint_o, 0);
        check_val({tag, "_act"},   BR_restoreAction_o,     0);
        check_val({tag, "_rv"},    BR_redirectValid_o,     0);
        check_val({tag, "_dest"},  BR_redirectDest_o,      0);
        check_val({tag, "_cnt"},   BR_mispredCnt_o,        0);
    endtask

    initial begin
        rst_n                = 1'b0;
        SBA_valid_w_i        = 1'b0;
        SBA_branchRisk_i     = 1'b0;
        SBA_corrTake_i       = 1'b0;
        SBA_corrDest_i       = 32'h0;
        SBA_VAddr_i          = 32'h0;
        SBA_repairAction_i   = 4'h0;
        SBA_checkPoint_i     = 32'h0;
        ID_dsIssued_w_i      = 1'b0;
        CP0_excOccur_w_i     = 1'b0;
        IF_redirectReady_w_i = 1'b0;

        step();
        step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();
        check_val("idle_busy", BR_busy_w_o, 0);

        // T1: taken mispredict, delay slot already issued
        drive_branch(1'b1, 32'h8000_1000, 32'h8000_0FF0, 4'b1011, 32'hDEAD_BEEF);
        ID_dsIssued_w_i = 1'b1;
        step();
        check_val("t1_busy_wds",  BR_busy_w_o,        1);
        check_val("t1_flush_wds", BR_flush_w_o,       0);
        check_val("t1_rv_wds",    BR_redirectValid_o, 0);
        // a second mispredict while busy must be ignored
        drive_branch(1'b1, 32'h1234_5678, 32'h0, 4'b1111, 32'h1111_1111);
        step();
        check_val("t1_flush",     BR_flush_w_o,           1);
        check_val("t1_restore",   BR_restoreValid_o,      1);
        check_val("t1_ckpt",      BR_restoreCheckPoint_o, 32'hDEAD_BEEF);
        check_val("t1_action",    BR_restoreAction_o,     3'b011);
        check_val("t1_rv_flush",  BR_redirectValid_o,     0);
        step();
        check_val("t1_flush_off", BR_flush_w_o,       0);
        check_val("t1_rst_off",   BR_restoreValid_o,  0);
        check_val("t1_rv",        BR_redirectValid_o, 1);
        check_val("t1_dest",      BR_redirectDest_o,  32'h8000_1000);
        SBA_valid_w_i        = 1'b0;
        IF_redirectReady_w_i = 1'b1;
        step();
        IF_redirectReady_w_i = 1'b0;
        check_val("t1_rv_done",   BR_redirectValid_o, 0);
        check_val("t1_busy_done", BR_busy_w_o,        0);
        check_val("t1_cnt",       BR_mispredCnt_o,    1);

        // T2: not-taken correction with PC wrap
        drive_branch(1'b0, 32'h5555_5555, 32'hFFFF_FFFC, 4'b1100, 32'h0000_00A5);
        ID_dsIssued_w_i = 1'b1;
        step();
        SBA_valid_w_i = 1'b0;
        step();
        check_val("t2_action", BR_restoreAction_o, 3'b100);
        step();
        check_val("t2_rv",   BR_redirectValid_o, 1);
        check_val("t2_dest", BR_redirectDest_o,  32'h0000_0004);
        IF_redirectReady_w_i = 1'b1;
        step();
        IF_redirectReady_w_i = 1'b0;
        check_val("t2_cnt", BR_mispredCnt_o, 2);

        // T3: delay slot held back five cycles
        drive_branch(1'b1, 32'h0040_0100, 32'h0040_0000, 4'b1001, 32'h0000_3333);
        ID_dsIssued_w_i = 1'b0;
        step();
        SBA_valid_w_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t3_busy%0d", i),  BR_busy_w_o,  1);
            check_val($sformatf("t3_flush%0d", i), BR_flush_w_o, 0);
            step();
        end
        ID_dsIssued_w_i = 1'b1;
        step();
        check_val("t3_flush", BR_flush_w_o, 1);
        step();
        check_val("t3_rv", BR_redirectValid_o, 1);
        IF_redirectReady_w_i = 1'b1;
        step();
        IF_redirectReady_w_i = 1'b0;
        check_val("t3_cnt", BR_mispredCnt_o, 3);

        // T4: IF stalls the redirect four cycles
        drive_branch(1'b1, 32'hBFC0_0380, 32'h8000_2000, 4'b1010, 32'h0000_4444);
        step();
        SBA_valid_w_i = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t4_rv%0d", i),   BR_redirectValid_o, 1);
            check_val($sformatf("t4_dest%0d", i), BR_redirectDest_o,  32'hBFC0_0380);
            check_val($sformatf("t4_cnt%0d", i),  BR_mispredCnt_o,    3);
            step();
        end
        IF_redirectReady_w_i = 1'b1;
        step();
        IF_redirectReady_w_i = 1'b0;
        check_val("t4_rv_done", BR_redirectValid_o, 0);
        check_val("t4_cnt",     BR_mispredCnt_o,    4);
        step();
        check_val("t4_cnt_hold", BR_mispredCnt_o, 4);

        // NEED_REPAIR clear: not accepted
        drive_branch(1'b1, 32'h0000_0010, 32'h0, 4'b0111, 32'h0);
        step();
        check_val("nr_busy", BR_busy_w_o, 0);
        SBA_valid_w_i = 1'b0;

        // T5: exception in WAIT_DS, then exception coincident with accept
        drive_branch(1'b1, 32'h0000_0020, 32'h0, 4'b1000, 32'h0);
        ID_dsIssued_w_i = 1'b0;
        step();
        SBA_valid_w_i = 1'b0;
        check_val("t5_busy_wds", BR_busy_w_o, 1);
        CP0_excOccur_w_i = 1'b1;
        ID_dsIssued_w_i  = 1'b1;
        step();
        check_val("t5_busy_exc",  BR_busy_w_o,  0);
        check_val("t5_flush_exc", BR_flush_w_o, 0);
        drive_branch(1'b1, 32'h0000_0030, 32'h0, 4'b1000, 32'h0);
        step();
        check_val("t5_busy_acc", BR_busy_w_o, 0);
        CP0_excOccur_w_i = 1'b0;
        SBA_valid_w_i    = 1'b0;
        step();
        check_val("t5_flush", BR_flush_w_o,       0);
        check_val("t5_rv",    BR_redirectValid_o, 0);
        check_val("t5_cnt",   BR_mispredCnt_o,    4);

        // exception together with ready in REDIRECT: no count
        drive_branch(1'b1, 32'h0000_0040, 32'h0, 4'b1000, 32'h0);
        step();
        SBA_valid_w_i = 1'b0;
        step();
        step();
        check_val("t5b_rv", BR_redirectValid_o, 1);
        CP0_excOccur_w_i     = 1'b1;
        IF_redirectReady_w_i = 1'b1;
        step();
        CP0_excOccur_w_i     = 1'b0;
        IF_redirectReady_w_i = 1'b0;
        check_val("t5b_rv_off", BR_redirectValid_o, 0);
        check_val("t5b_busy",   BR_busy_w_o,        0);
        check_val("t5b_cnt",    BR_mispredCnt_o,    4);

        // T6: asynchronous reset mid-REDIRECT
        drive_branch(1'b1, 32'h9000_0000, 32'h0, 4'b1111, 32'h7777_7777);
        step();
        SBA_valid_w_i = 1'b0;
        step();
        step();
        check_val("t6_rv_pre", BR_redirectValid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        step();
        rst_n = 1'b1;
        step();
        check_val("t6_busy_after", BR_busy_w_o,     0);
        check_val("t6_cnt_after",  BR_mispredCnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
